pw_act_serializer: RTL and testbench
====================================

Name: pw_act_serializer

Overview:
- Consumer end of a pointwise-conv layer's output interface.
- Captures the wide per-pixel activation vector (NUM_CH x ACT_W, channel 0 in LSBs) whenever the layer's one-cycle `ready` strobe fires.
- Buffers whole vectors in a small FIFO, then streams them out one channel per beat on a valid/ready channel toward the next layer's loader or the DMA writer.
- The producer has no backpressure, so overflow is detected and flagged, never silently hidden.

Parameters:
- NUM_CH, 16, channels per input vector
- ACT_W, 16, bits per activation
- DEPTH, 4, FIFO depth in whole vectors (power of 2, >=2)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_strobe  in  1  producer vector-valid pulse (driven by the layer's ready)
- in_act  in  NUM_CH*ACT_W  activation vector; channel c at [c*ACT_W +: ACT_W]
- out_valid  out  1  beat available
- out_ready  in  1  downstream accepts beat
- out_data  out  ACT_W  channel value
- out_ch  out  $clog2(NUM_CH)  channel index of out_data
- out_last  out  1  final beat of a vector
- level  out  $clog2(DEPTH)+1  vectors currently held, including the one being drained
- overflow  out  1  sticky: a strobe was dropped

Behaviour:
- Reset (sync, rst=1 at posedge): FIFO empty, level=0, channel counter=0, overflow=0, out_valid=0. out_data/out_ch/out_last read 0 while out_valid=0.
- rst overrides everything in the same cycle. A vector mid-drain is discarded. Strobes during reset are ignored and do not set overflow.
- Write rule:
  - in_strobe=1 and level<DEPTH: push in_act at posedge.
  - in_strobe=1 and level==DEPTH: vector dropped, overflow<=1, held until rst.
  - Full is judged on the registered level only. A simultaneous final-beat pop does not make room that cycle.
- Latency: strobe at posedge t gives out_valid=1 from t+1 when the FIFO was empty. No combinational path from in_* to out_*.
- Read side:
  - out_valid = (level!=0).
  - out_data = head[ch*ACT_W +: ACT_W], out_ch = ch, out_last = (ch==NUM_CH-1).
  - Beat transfers when out_valid & out_ready.
  - On a transfer with out_last=0: ch increments.
  - On a transfer with out_last=1: ch<=0 and the head pops.
- Output stability: while out_valid=1 and out_ready=0, out_data/out_ch/out_last hold stable.
- Simultaneous push and pop in one cycle: level unchanged, pointers both advance (mod DEPTH wrap).
- Throughput: 1 beat/cycle when out_ready=1. A vector drains in NUM_CH cycles, so back-to-back strobes faster than 1 per NUM_CH cycles eventually overflow. This is by design; overflow is the diagnostic.
- Data is passed unmodified (no sign or width change).

Optional Feature:
- Macro: PW_ACT_SERIALIZER_ZERO_SKIP_EN
- Defined:
  - Beats whose channel value is 0 are skipped. ch jumps to the next nonzero channel of the head vector via a priority search from ch.
  - Channel NUM_CH-1 is always emitted, even if zero, so out_last still delimits every vector.
  - An all-zero vector yields exactly one beat (ch=NUM_CH-1, data 0, last=1).
  - When a vector becomes head, ch starts at its first nonzero channel.
  - out_ch carries the true channel index.
- Undefined: every channel is emitted in order 0..NUM_CH-1. No priority logic is synthesized.

Decomposition:
- Package pw_ser_pkg: localparams NUM_CH and ACT_W defaults; typedef act_vec_t (logic [NUM_CH*ACT_W-1:0]); typedef ch_idx_t (logic [$clog2(NUM_CH)-1:0]); function first_nonzero(act_vec_t, ch_idx_t), used only under the macro.
- Sub-module pw_ser_fifo: synchronous-reset vector FIFO with push/pop/level and full/empty. The serializer top holds the channel counter, output mux and overflow flag.

Test Plan:
- Reset: rst high 3 cycles with in_strobe=1 -> level=0, out_valid=0, overflow=0 after release.
- Single vector, channel c = 16'h0100+c, out_ready=1 -> 16 consecutive beats 0x0100..0x010F, out_ch 0..15, out_last only on ch 15, out_valid from strobe+1.
- Backpressure: out_ready toggles 1,0,0,1 per cycle -> no beat lost or duplicated; data stable during the stall cycles.
- Overflow: 5 strobes on consecutive cycles, out_ready=0 -> level=4, overflow=1. Draining yields vectors 1-4 only; the 5th is absent.
- Push/pop same cycle: level=4, final beat accepted while in_strobe=1 -> strobe dropped and overflow=1 (full on registered level). With level=3, the same case -> level stays 3.
- ZERO_SKIP_EN: vector with only ch3=7 and ch9=2 nonzero -> beats (3,7), (9,2), (15,0,last). All-zero vector -> single beat (15,0,last).

Source files
------------

// File: rtl/pw_ser_pkg.sv
// Shared types and helpers for the pointwise-conv activation serializer.
// first_nonzero backs the PW_ACT_SERIALIZER_ZERO_SKIP_EN build only.
package pw_ser_pkg;

   localparam int NUM_CH = 16;
   localparam int ACT_W  = 16;

   typedef logic [NUM_CH*ACT_W-1:0]   act_vec_t;
   typedef logic [$clog2(NUM_CH)-1:0] ch_idx_t;

   // Lowest channel >= from holding a nonzero value; last channel otherwise.
   function automatic ch_idx_t first_nonzero(
      input act_vec_t v,
      input ch_idx_t  from
   );
      ch_idx_t r;
      r = ch_idx_t'(NUM_CH - 1);
      for (int c = NUM_CH - 1; c >= 0; c--) begin
         if (c >= int'(from) && v[c*ACT_W +: ACT_W] != '0)
            r = ch_idx_t'(c);
      end
      return r;
   endfunction

endpackage

// File: rtl/pw_ser_fifo.sv
// Whole-vector FIFO with synchronous reset and a registered level count.
// push/pop are ignored when full/empty respectively.
module pw_ser_fifo #(
   parameter int W     = 256,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic                    pop,
   input  logic [W-1:0]            din,
   output logic [W-1:0]            head,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    full,
   output logic                    empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (level == (AW+1)'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)
            level <= level + 1'b1;
         else if (do_pop && !do_push)
            level <= level - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && do_push)
         mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/pw_act_serializer.sv
// Buffers per-pixel activation vectors and streams them one channel per beat.
// Optional zero-channel skipping: PW_ACT_SERIALIZER_ZERO_SKIP_EN.
module pw_act_serializer
   import pw_ser_pkg::*;
#(
   parameter int NUM_CH = 16,
   parameter int ACT_W  = 16,
   parameter int DEPTH  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_strobe,
   input  logic [NUM_CH*ACT_W-1:0]   in_act,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [ACT_W-1:0]          out_data,
   output logic [$clog2(NUM_CH)-1:0] out_ch,
   output logic                      out_last,
   output logic [$clog2(DEPTH):0]    level,
   output logic                      overflow
);

   localparam int CW = $clog2(NUM_CH);
   localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);

   logic [NUM_CH*ACT_W-1:0] head;
   logic                    full;
   logic                    empty;
   logic                    fire;
   logic                    last;
   logic                    pop;
   logic [CW-1:0]           base;
   logic [CW-1:0]           cur;

   pw_ser_fifo #(
      .W     (NUM_CH*ACT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_strobe),
      .pop   (pop),
      .din   (in_act),
      .head  (head),
      .level (level),
      .full  (full),
      .empty (empty)
   );

   // base is the next channel to consider; cur is the one presented.
`ifdef PW_ACT_SERIALIZER_ZERO_SKIP_EN
   assign cur = first_nonzero(head, base);
`else
   assign cur = base;
`endif

   assign out_valid = ~empty;
   assign last      = (cur == LAST_CH);
   assign fire      = out_valid & out_ready;
   assign pop       = fire & last;
   assign out_ch    = out_valid ? cur : '0;
   assign out_last  = out_valid & last;
   assign out_data  = out_valid ? head[cur*ACT_W +: ACT_W] : '0;

   always_ff @(posedge clk) begin
      if (rst)
         base <= '0;
      else if (fire)
         base <= last ? '0 : cur + 1'b1;
   end

   // Full is taken from the registered level, so a same-cycle pop never helps.
   always_ff @(posedge clk) begin
      if (rst)
         overflow <= 1'b0;
      else if (in_strobe && full)
         overflow <= 1'b1;
   end

endmodule

// File: tb/tb_pw_act_serializer.sv
// Testbench for pw_act_serializer: directed and random stimulus against a
// queue-based reference model of the vector stream.
module tb_pw_act_serializer;
   import pw_ser_pkg::*;

   localparam int D = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           in_strobe = 1'b0;
   act_vec_t       in_act = '0;
   logic           out_ready = 1'b0;
   logic           out_valid;
   logic [ACT_W-1:0] out_data;
   ch_idx_t        out_ch;
   logic           out_last;
   logic [2:0]     level;
   logic           overflow;

   int n_chk = 0;
   int n_fail = 0;
   bit checking = 0;

   act_vec_t q[$];
   int pos = 0;
   bit ovf = 0;

   logic [ACT_W-1:0] bdat[$];
   int bch[$];
   bit blast[$];

   pw_act_serializer #(
      .NUM_CH (NUM_CH),
      .ACT_W  (ACT_W),
      .DEPTH  (D)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_strobe (in_strobe),
      .in_act    (in_act),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_last  (out_last),
      .level     (level),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Channel the model expects on the output for the current head.
   function automatic int exp_ch();
      act_vec_t h;
      int c;
      h = q[0];
      c = pos;
`ifdef PW_ACT_SERIALIZER_ZERO_SKIP_EN
      while (c < NUM_CH - 1 && h[c*ACT_W +: ACT_W] == '0)
         c++;
`endif
      return c;
   endfunction

   task automatic check_outputs();
      act_vec_t h;
      int c;
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("level", 32'(level), q.size());
      chk("overflow", 32'(overflow), 32'(ovf));
      if (q.size() != 0) begin
         h = q[0];
         c = exp_ch();
         chk("out_data", 32'(out_data), 32'(h[c*ACT_W +: ACT_W]));
         chk("out_ch", 32'(out_ch), c);
         chk("out_last", 32'(out_last), 32'(c == NUM_CH - 1));
      end else begin
         chk("idle_data", 32'(out_data), 0);
         chk("idle_ch", 32'(out_ch), 0);
         chk("idle_last", 32'(out_last), 0);
      end
   endtask

   task automatic step(input logic s, input act_vec_t v, input logic r);
      bit full;
      int c;
      in_strobe = s;
      in_act = v;
      out_ready = r;
      if (checking)
         check_outputs();
      if (out_valid && out_ready) begin
         bdat.push_back(out_data);
         bch.push_back(int'(out_ch));
         blast.push_back(out_last);
      end
      @(posedge clk);
      if (rst) begin
         q.delete();
         pos = 0;
         ovf = 0;
      end else begin
         full = (q.size() == D);
         if (q.size() != 0 && r) begin
            c = exp_ch();
            if (c == NUM_CH - 1) begin
               q.delete(0);
               pos = 0;
            end else begin
               pos = c + 1;
            end
         end
         if (s) begin
            if (full)
               ovf = 1;
            else
               q.push_back(v);
         end
      end
      #1;
   endtask

   task automatic idle(input int n, input logic r);
      for (int i = 0; i < n; i++)
         step(1'b0, '0, r);
   endtask

   task automatic clear_beats();
      bdat.delete();
      bch.delete();
      blast.delete();
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      step(1'b1, '1, 1'b0);
      rst = 1'b0;
   endtask

   function automatic act_vec_t inc_vec(input logic [ACT_W-1:0] b);
      act_vec_t v;
      for (int c = 0; c < NUM_CH; c++)
         v[c*ACT_W +: ACT_W] = b + ACT_W'(c);
      return v;
   endfunction

   function automatic act_vec_t rand_vec();
      act_vec_t v;
      for (int c = 0; c < NUM_CH; c++)
         v[c*ACT_W +: ACT_W] = ($urandom_range(0, 3) == 0) ?
                               '0 : ACT_W'($urandom);
      return v;
   endfunction

   initial begin
      act_vec_t v;
      int pat[4] = '{1, 0, 0, 1};

      @(posedge clk);
      #1;
      // Reset held with strobes active
      rst = 1'b1;
      for (int i = 0; i < 3; i++)
         step(1'b1, rand_vec(), 1'b1);
      rst = 1'b0;
      checking = 1;
      chk("rst_level", 32'(level), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_overflow", 32'(overflow), 0);
      idle(2, 1'b1);

      // Single vector, free-running consumer
      clear_beats();
      step(1'b1, inc_vec(16'h0100), 1'b1);
      chk("latency_valid", 32'(out_valid), 1);
      idle(17, 1'b1);
      chk("single_count", bdat.size(), 16);
      for (int i = 0; i < bdat.size() && i < 16; i++) begin
         chk("single_data", 32'(bdat[i]), 32'h0100 + i);
         chk("single_ch", bch[i], i);
         chk("single_last", 32'(blast[i]), 32'(i == 15));
      end

      // Backpressure 1,0,0,1
      clear_beats();
      step(1'b1, inc_vec(16'h0200), 1'b1);
      for (int i = 0; i < 80; i++)
         step(1'b0, '0, pat[(i + 1) % 4] != 0);
      chk("bp_count", bdat.size(), 16);
      for (int i = 0; i < bdat.size() && i < 16; i++)
         chk("bp_data", 32'(bdat[i]), 32'h0200 + i);

      // Overflow: five strobes, consumer stalled
      for (int k = 1; k <= 5; k++)
         step(1'b1, inc_vec(16'(k * 16'h1000 + 1)), 1'b0);
      chk("ovf_level", 32'(level), 4);
      chk("ovf_flag", 32'(overflow), 1);
      clear_beats();
      idle(70, 1'b1);
      chk("ovf_count", bdat.size(), 64);
      for (int i = 0; i < bdat.size() && i < 64; i++)
         chk("ovf_data", 32'(bdat[i]),
             32'((i / 16 + 1) * 32'h1000 + 1 + (i % 16)));
      chk("ovf_sticky", 32'(overflow), 1);

      // Push during final beat with FIFO full: strobe dropped
      pulse_reset();
      for (int k = 1; k <= 4; k++)
         step(1'b1, inc_vec(16'(k * 16'h0100 + 1)), 1'b0);
      idle(15, 1'b1);
      step(1'b1, inc_vec(16'h7001), 1'b1);
      chk("pp_full_level", 32'(level), 3);
      chk("pp_full_ovf", 32'(overflow), 1);
      idle(60, 1'b1);

      // Same case with three held: level stays put
      pulse_reset();
      for (int k = 1; k <= 3; k++)
         step(1'b1, inc_vec(16'(k * 16'h0100 + 1)), 1'b0);
      idle(15, 1'b1);
      step(1'b1, inc_vec(16'h7001), 1'b1);
      chk("pp_three_level", 32'(level), 3);
      chk("pp_three_ovf", 32'(overflow), 0);
      idle(60, 1'b1);

      // Sparse and all-zero vectors
      clear_beats();
      v = '0;
      v[3*ACT_W +: ACT_W] = 16'd7;
      v[9*ACT_W +: ACT_W] = 16'd2;
      step(1'b1, v, 1'b1);
      idle(20, 1'b1);
`ifdef PW_ACT_SERIALIZER_ZERO_SKIP_EN
      chk("sparse_count", bdat.size(), 3);
      if (bdat.size() == 3) begin
         chk("sparse_ch0", bch[0], 3);
         chk("sparse_d0", 32'(bdat[0]), 7);
         chk("sparse_ch1", bch[1], 9);
         chk("sparse_d1", 32'(bdat[1]), 2);
         chk("sparse_ch2", bch[2], 15);
         chk("sparse_d2", 32'(bdat[2]), 0);
         chk("sparse_last", 32'(blast[2]), 1);
      end
`else
      chk("sparse_count", bdat.size(), 16);
      if (bdat.size() == 16) begin
         chk("sparse_d3", 32'(bdat[3]), 7);
         chk("sparse_d9", 32'(bdat[9]), 2);
         chk("sparse_d0", 32'(bdat[0]), 0);
      end
`endif
      clear_beats();
      step(1'b1, '0, 1'b1);
      idle(20, 1'b1);
`ifdef PW_ACT_SERIALIZER_ZERO_SKIP_EN
      chk("zero_count", bdat.size(), 1);
      if (bdat.size() == 1) begin
         chk("zero_ch", bch[0], 15);
         chk("zero_last", 32'(blast[0]), 1);
      end
`else
      chk("zero_count", bdat.size(), 16);
`endif

      // Random traffic, occasional reset
      for (int i = 0; i < 1500; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         step($urandom_range(0, 9) == 0, rand_vec(),
              $urandom_range(0, 3) != 0);
         rst = 1'b0;
      end
      idle(100, 1'b1);
      chk("final_level", 32'(level), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
